// File: rtl/apb_master_multi.sv
// apb_master_multi: APB4 master that turns a valid/ready command stream into
// APB transfers to one of NUM_SLAVES slaves, with per-slave PREADY/PSLVERR and
// an optional wait-state timeout.
//
// Ports:
//   PCLK, PRESETn                      clock, async active-low reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_write, cmd_addr, cmd_wdata,    command payload (slave index taken from
//   cmd_strb                           the top log2(NUM_SLAVES) address bits)
//   rsp_valid, rsp_rdata, rsp_err,     one-cycle completion pulse and status
//   rsp_timeout
//   PSEL, PENABLE, PWRITE, PADDR,      APB request side (one-hot PSEL)
//   PWDATA, PSTRB
//   PREADY, PSLVERR, PRDATA            per-slave APB return side
module apb_master_multi #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_write,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr,
    input  logic [DATA_WIDTH-1:0]            cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]          cmd_strb,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             rsp_timeout,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [DATA_WIDTH/8-1:0]          PSTRB,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned SEL_W  = $clog2(NUM_SLAVES);
    // A zero TIMEOUT still needs a 1-bit counter to keep the logic legal.
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e                  state_q,       state_d;
    logic [SEL_W-1:0]        sel_q,         sel_d;
    logic [CNT_W-1:0]        wait_cnt_q,    wait_cnt_d;
    logic                    cmd_ready_q,   cmd_ready_d;
    logic                    rsp_valid_q,   rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q,   rsp_rdata_d;
    logic                    rsp_err_q,     rsp_err_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic [NUM_SLAVES-1:0]   psel_q,        psel_d;
    logic                    penable_q,     penable_d;
    logic                    pwrite_q,      pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q,       paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q,      pwdata_d;
    logic [STRB_W-1:0]       pstrb_q,       pstrb_d;

    logic                    sel_ready_c;
    logic                    sel_err_c;
    logic [DATA_WIDTH-1:0]   sel_rdata_c;

    // Return-path mux: only the addressed slave is ever observed.
    always_comb begin
        sel_ready_c = 1'b0;
        sel_err_c   = 1'b0;
        sel_rdata_c = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_ready_c = PREADY[k];
                sel_err_c   = PSLVERR[k];
                sel_rdata_c = PRDATA[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        wait_cnt_d    = wait_cnt_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                // cmd_ready_q gates acceptance so the first cycle out of reset
                // cannot take a command.
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = ST_SETUP;
                    cmd_ready_d = 1'b0;
                    sel_d       = cmd_addr[ADDR_WIDTH-1 -: SEL_W];
                    psel_d      = NUM_SLAVES'(1) << cmd_addr[ADDR_WIDTH-1 -: SEL_W];
                    penable_d   = 1'b0;
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                    pstrb_d     = cmd_write ? cmd_strb : '0;
                    wait_cnt_d  = '0;
                end
            end

            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end

            ST_ACCESS: begin
                // PREADY wins over a timeout that expires on the same edge.
                if (sel_ready_c) begin
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_err_c;
                    rsp_rdata_d = pwrite_q ? '0 : sel_rdata_c;
                end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_W'(TIMEOUT))) begin
                    state_d       = ST_IDLE;
                    cmd_ready_d   = 1'b1;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b0;
                psel_d      = '0;
                penable_d   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            wait_cnt_q    <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            wait_cnt_q    <= wait_cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;

endmodule
